// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, function-code, state and decode-entry definitions
package cpu_pkg;

   localparam logic [3:0] OPC_ALU = 4'b0000;

   localparam logic [3:0] FN_ADD  = 4'b1010;
   localparam logic [3:0] FN_ADDI = 4'b1001;
   localparam logic [3:0] FN_SUB  = 4'b1100;
   localparam logic [3:0] FN_AND  = 4'b1110;
   localparam logic [3:0] FN_OR   = 4'b0010;
   localparam logic [3:0] FN_XOR  = 4'b0110;
   localparam logic [3:0] FN_NOT  = 4'b1011;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   typedef struct packed {
      logic s_sub;
      logic s_fas;
      logic s_and;
      logic s_or;
      logic s_xor;
      logic s_not;
      logic is_alu;
      logic illegal;
   } dec_t;

   localparam dec_t DEC_NONE = '0;

endpackage

// File: rtl/alu_fn_decode.sv
// rtl/alu_fn_decode.sv - combinational ALU select decode of one instruction word
module alu_fn_decode
   import cpu_pkg::*;
#(
   parameter int IR_W   = 16,
   parameter int OPC_HI = IR_W - 1,
   parameter int FN_LO  = 4
) (
   input  logic [IR_W-1:0] ir,
   output dec_t            dec
);

   logic [3:0] opc;
   logic [3:0] fn;
   logic       unused_ir;

   assign opc       = ir[OPC_HI -: 4];
   assign fn        = ir[FN_LO +: 4];
   assign unused_ir = ^ir;

   always_comb begin
      dec = DEC_NONE;
      if (opc == OPC_ALU) begin
         dec.is_alu = 1'b1;
         case (fn)
            FN_ADD, FN_ADDI: dec.s_fas = 1'b1;
            FN_SUB: begin
               dec.s_sub = 1'b1;
               dec.s_fas = 1'b1;
            end
            FN_AND:  dec.s_and   = 1'b1;
            FN_OR:   dec.s_or    = 1'b1;
            FN_XOR:  dec.s_xor   = 1'b1;
            FN_NOT:  dec.s_not   = 1'b1;
            default: dec.illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with 2-entry skid buffer and illegal counter
module decode_stage
   import cpu_pkg::*;
#(
   parameter int IR_W   = 16,
   parameter int OPC_HI = IR_W - 1,
   parameter int FN_LO  = 4,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IR_W-1:0]  ir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IR_W-1:0]  out_ir,
   output logic             s_sub,
   output logic             s_fas,
   output logic             s_and,
   output logic             s_or,
   output logic             s_xor,
   output logic             s_not,
   output logic             is_alu,
   output logic             illegal,
   output logic [CNT_W-1:0] ill_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic [IR_W-1:0] skid_ir;
   dec_t            main_dec;
   dec_t            skid_dec;
   dec_t            in_dec;
   logic            accept;
   logic            pop;

   alu_fn_decode #(
      .IR_W   (IR_W),
      .OPC_HI (OPC_HI),
      .FN_LO  (FN_LO)
   ) u_dec (
      .ir  (ir),
      .dec (in_dec)
   );

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: if (accept) state_nxt = ST_ONE;
         ST_ONE: begin
            if (accept && !pop)      state_nxt = ST_TWO;
            else if (pop && !accept) state_nxt = ST_EMPTY;
         end
         ST_TWO:   if (pop) state_nxt = ST_ONE;
         default:  state_nxt = ST_EMPTY;
      endcase
   end

   // Handshake flags are registered from the next state so neither depends on out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt != ST_TWO);
         out_valid <= (state_nxt != ST_EMPTY);
      end
   end

   // Main entry select bits are cleared on drain so outputs read 0 while empty; out_ir is kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_ir   <= '0;
         main_dec <= DEC_NONE;
         skid_ir  <= '0;
         skid_dec <= DEC_NONE;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  out_ir   <= ir;
                  main_dec <= in_dec;
               end
            end
            ST_ONE: begin
               if (accept && pop) begin
                  out_ir   <= ir;
                  main_dec <= in_dec;
               end else if (accept) begin
                  skid_ir  <= ir;
                  skid_dec <= in_dec;
               end else if (pop) begin
                  main_dec <= DEC_NONE;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  out_ir   <= skid_ir;
                  main_dec <= skid_dec;
               end
            end
            default: main_dec <= DEC_NONE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ill_cnt <= '0;
      end else if (accept && in_dec.illegal && (ill_cnt != CNT_MAX)) begin
         ill_cnt <= ill_cnt + CNT_W'(1);
      end
   end

   assign s_sub   = main_dec.s_sub;
   assign s_fas   = main_dec.s_fas;
   assign s_and   = main_dec.s_and;
   assign s_or    = main_dec.s_or;
   assign s_xor   = main_dec.s_xor;
   assign s_not   = main_dec.s_not;
   assign is_alu  = main_dec.is_alu;
   assign illegal = main_dec.illegal;

endmodule
